// File: rtl/cpu_sram_bridge_if.sv
// Core-side byte bus of the SRAM bridge.
// The core drives address/write data/write request; the bridge answers with
// read data and a one-clock clock-enable pulse per completed bus cycle.
interface cpu_sram_bridge_if;
  logic [19:0] address;
  logic [7:0]  out;
  logic        we;
  logic [7:0]  in;
  logic        ce;

  modport master (
    output address,
    output out,
    output we,
    input  in,
    input  ce
  );

  modport slave (
    input  address,
    input  out,
    input  we,
    output in,
    output ce
  );
endinterface

// File: rtl/cpu_sram_bridge.sv
// Memory-side responder for the core byte bus, backed by an asynchronous
// 16-bit SRAM with WAIT wait states. The core is stalled by holding ce low;
// ce pulses for one clock when read data is valid or a write has finished.
// A repeated read of the most recently SRAM-read address is answered from
// the held read data without touching the SRAM.
module cpu_sram_bridge #(
  parameter int unsigned WAIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  cpu_sram_bridge_if.slave bus,
  output logic [18:0]      sram_addr,
  input  logic [15:0]      sram_dq_i,
  output logic [15:0]      sram_dq_o,
  output logic             sram_dq_oe,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic             sram_ub_n,
  output logic             sram_lb_n
);

  typedef enum logic [1:0] {
    START  = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [19:0] addr_r, addr_s;
  logic        we_r, we_s;
  logic [7:0]  in_r, in_s;
  logic        ce_r, ce_s;
  logic [19:0] last_addr_r, last_addr_s;
  logic        last_valid_r, last_valid_s;
  logic [18:0] sram_addr_r, sram_addr_s;
  logic [15:0] dq_o_r, dq_o_s;
  logic        dq_oe_r, dq_oe_s;
  logic        ce_n_r, ce_n_s;
  logic        oe_n_r, oe_n_s;
  logic        we_n_r, we_n_s;
  logic        ub_n_r, ub_n_s;
  logic        lb_n_r, lb_n_s;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= START;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    addr_s       = addr_r;
    we_s         = we_r;
    in_s         = in_r;
    ce_s         = 1'b0;
    last_addr_s  = last_addr_r;
    last_valid_s = last_valid_r;
    sram_addr_s  = sram_addr_r;
    dq_o_s       = dq_o_r;
    dq_oe_s      = dq_oe_r;
    ce_n_s       = ce_n_r;
    oe_n_s       = oe_n_r;
    we_n_s       = we_n_r;
    ub_n_s       = ub_n_r;
    lb_n_s       = lb_n_r;

    case (state_r)
      START: begin
        // ce is low here, so the core keeps its request stable while sampled
        addr_s = bus.address;
        we_s   = bus.we;
        if (!bus.we && last_valid_r && (bus.address == last_addr_r)) begin
          // Same byte as the last SRAM read: in already holds it
          state_s = DONE;
          ce_s    = 1'b1;
        end else begin
          sram_addr_s = bus.address[19:1];
          lb_n_s      = bus.address[0];
          ub_n_s      = ~bus.address[0];
          dq_o_s      = {bus.out, bus.out};
          cnt_s       = WAIT_CNT;
          ce_n_s      = 1'b0;
          oe_n_s      = bus.we;
          dq_oe_s     = bus.we;
          state_s     = ACCESS;
          if (bus.we) begin
            last_valid_s = 1'b0;
          end else begin
            last_valid_s = last_valid_r;
          end
        end
      end

      ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_s = DONE;
          ce_s    = 1'b1;
          ce_n_s  = 1'b1;
          oe_n_s  = 1'b1;
          we_n_s  = 1'b1;
          if (!we_r) begin
            in_s         = addr_r[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
            last_addr_s  = addr_r;
            last_valid_s = 1'b1;
          end else begin
            in_s = in_r;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
          // First ACCESS clock is address setup; the write strobe follows it
          if (we_r) begin
            we_n_s = 1'b0;
          end else begin
            we_n_s = we_n_r;
          end
        end
      end

      DONE: begin
        // Data and lanes were held through DONE for write hold time
        state_s = START;
        dq_oe_s = 1'b0;
        ub_n_s  = 1'b1;
        lb_n_s  = 1'b1;
      end

      default: begin
        state_s = START;
      end
    endcase
  end

  // Datapath and SRAM pin registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r        <= 4'd0;
      addr_r       <= 20'd0;
      we_r         <= 1'b0;
      in_r         <= 8'h00;
      ce_r         <= 1'b0;
      last_addr_r  <= 20'd0;
      last_valid_r <= 1'b0;
      sram_addr_r  <= 19'd0;
      dq_o_r       <= 16'h0000;
      dq_oe_r      <= 1'b0;
      ce_n_r       <= 1'b1;
      oe_n_r       <= 1'b1;
      we_n_r       <= 1'b1;
      ub_n_r       <= 1'b1;
      lb_n_r       <= 1'b1;
    end else begin
      cnt_r        <= cnt_s;
      addr_r       <= addr_s;
      we_r         <= we_s;
      in_r         <= in_s;
      ce_r         <= ce_s;
      last_addr_r  <= last_addr_s;
      last_valid_r <= last_valid_s;
      sram_addr_r  <= sram_addr_s;
      dq_o_r       <= dq_o_s;
      dq_oe_r      <= dq_oe_s;
      ce_n_r       <= ce_n_s;
      oe_n_r       <= oe_n_s;
      we_n_r       <= we_n_s;
      ub_n_r       <= ub_n_s;
      lb_n_r       <= lb_n_s;
    end
  end

  assign bus.in     = in_r;
  assign bus.ce     = ce_r;
  assign sram_addr  = sram_addr_r;
  assign sram_dq_o  = dq_o_r;
  assign sram_dq_oe = dq_oe_r;
  assign sram_ce_n  = ce_n_r;
  assign sram_oe_n  = oe_n_r;
  assign sram_we_n  = we_n_r;
  assign sram_ub_n  = ub_n_r;
  assign sram_lb_n  = lb_n_r;

endmodule
